// File: rtl/icache_fill_ctrl.sv
// Instruction-fetch front end: zero-latency icache lookup on hit, two-beat
// line fill from unified memory on miss, saturating hit/miss counters.
module icache_fill_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      pc,
  input  logic             fetch_en,
  input  logic             flush,
  output logic [15:0]      instr,
  output logic             instr_vld,
  output logic             pc_stall,
  output logic [13:0]      ic_addr,
  output logic             ic_re,
  output logic             ic_we,
  output logic [63:0]      ic_wr_data,
  input  logic [63:0]      ic_rd_data,
  input  logic             ic_hit,
  output logic [14:0]      mem_addr,
  output logic             mem_re,
  input  logic             mem_rdy,
  input  logic [31:0]      mem_rd_data,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned LINE_W = 14;
  localparam int unsigned WORD_W = 32;
  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ0  = 2'd1,
    S_REQ1  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [LINE_W-1:0]  miss_addr_q, miss_addr_d;
  logic [WORD_W-1:0]  lo_buf_q, lo_buf_d;
  logic [WORD_W-1:0]  hi_buf_q, hi_buf_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [15:0]        sel_instr;

  // Pick instruction pc[1:0] out of the addressed line
  always_comb begin
    sel_instr = ic_rd_data[{pc[1:0], 4'h0} +: 16];
  end

  // Next-state and output decode; IDLE outputs follow the live lookup
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    lo_buf_d    = lo_buf_q;
    hi_buf_d    = hi_buf_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    instr       = NOP;
    instr_vld   = 1'b0;
    pc_stall    = 1'b0;
    ic_addr     = '0;
    ic_re       = 1'b0;
    ic_we       = 1'b0;
    ic_wr_data  = '0;
    mem_addr    = '0;
    mem_re      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Lookup is held quiet while reset is asserted
        if (rst_n) begin
          ic_addr = pc[15:2];
          ic_re   = fetch_en;
          if (fetch_en) begin
            if (ic_hit) begin
              instr     = flush ? NOP : sel_instr;
              instr_vld = ~flush;
              if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
              pc_stall    = 1'b1;
              miss_addr_d = pc[15:2];
              if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
              state_d     = S_REQ0;
            end
          end
        end
      end
      S_REQ0: begin
        pc_stall = 1'b1;
        mem_re   = 1'b1;
        mem_addr = {miss_addr_q, 1'b0};
        if (mem_rdy) begin
          lo_buf_d = mem_rd_data;
          state_d  = S_REQ1;
        end
      end
      S_REQ1: begin
        pc_stall = 1'b1;
        mem_re   = 1'b1;
        mem_addr = {miss_addr_q, 1'b1};
        if (mem_rdy) begin
          hi_buf_d = mem_rd_data;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        pc_stall   = 1'b1;
        ic_we      = 1'b1;
        ic_addr    = miss_addr_q;
        ic_wr_data = {hi_buf_q, lo_buf_q};
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, fill buffers and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      lo_buf_q    <= '0;
      hi_buf_q    <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      lo_buf_q    <= lo_buf_d;
      hi_buf_q    <= hi_buf_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: icache and memory environment plus a
// line-level reference model (which lines are cached, expected stall length,
// expected counter values).
module tb_icache_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic        fetch_en;
  logic        flush;
  logic [15:0] instr;
  logic        instr_vld;
  logic        pc_stall;
  logic [13:0] ic_addr;
  logic        ic_re;
  logic        ic_we;
  logic [63:0] ic_wr_data;
  logic [63:0] ic_rd_data;
  logic        ic_hit;
  logic [14:0] mem_addr;
  logic        mem_re;
  logic        mem_rdy;
  logic [31:0] mem_rd_data;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  icache_fill_ctrl #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .instr       (instr),
    .instr_vld   (instr_vld),
    .pc_stall    (pc_stall),
    .ic_addr     (ic_addr),
    .ic_re       (ic_re),
    .ic_we       (ic_we),
    .ic_wr_data  (ic_wr_data),
    .ic_rd_data  (ic_rd_data),
    .ic_hit      (ic_hit),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_rdy     (mem_rdy),
    .mem_rd_data (mem_rd_data),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: icache storage written by the DUT, read combinationally
  logic [63:0] cache_data [16384];
  bit          cache_vld  [16384];
  int          we_pulses = 0;

  assign ic_hit     = cache_vld[ic_addr];
  assign ic_rd_data = cache_data[ic_addr];

  always @(posedge clk) begin
    if (ic_we) begin
      cache_data[ic_addr] <= ic_wr_data;
      cache_vld[ic_addr]  <= 1'b1;
      we_pulses           <= we_pulses + 1;
    end
  end

  // Reference model state
  logic [31:0] mem [32768];
  bit          exp_vld [16384];
  int          m_hit  = 0;
  int          m_miss = 0;
  int          tests  = 0;
  int          fails  = 0;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic logic [63:0] line_of(input logic [13:0] l);
    return {mem[{l, 1'b1}], mem[{l, 1'b0}]};
  endfunction

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    logic [63:0] d;
    d = line_of(a[15:2]);
    return d[{a[1:0], 4'h0} +: 16];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_hit_cnt"},  64'(hit_cnt),  64'(m_hit));
    chk({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(m_miss));
  endtask

  // One fetch of address a; memory answers each beat after lat request
  // cycles. With redir_en, the pc is redirected to ra with a flush in the
  // first REQ1 cycle of the fill.
  task automatic fetch(input logic [15:0] a, input int lat, input bit redir_en,
                       input logic [15:0] ra);
    logic [15:0] cur_pc, fp;
    logic [13:0] ln, fill_ln;
    int          beat, wait_c, stall, exp_stall;
    bit          done, miss0, redirected;
    cur_pc = a; ln = a[15:2]; fill_ln = ln;
    beat = 0; wait_c = 0; stall = 0; done = 1'b0; redirected = 1'b0;
    miss0 = !exp_vld[ln];
    exp_stall = miss0 ? 2 * lat + 2 : 0;
    if (miss0) m_miss = sat_inc(m_miss);
    exp_vld[ln] = 1'b1;
    fp = a;
    if (redir_en && miss0) begin
      fp = ra;
      if (!exp_vld[ra[15:2]]) begin
        exp_stall += 2 * lat + 2;
        m_miss = sat_inc(m_miss);
      end
      exp_vld[ra[15:2]] = 1'b1;
    end
    m_hit = sat_inc(m_hit);

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      pc = cur_pc; fetch_en = 1'b1; flush = 1'b0; mem_rdy = 1'b0; mem_rd_data = '0;
      if (mem_re) begin
        if (redir_en && !redirected && beat == 1) begin
          cur_pc = ra; pc = ra; flush = 1'b1; redirected = 1'b1;
        end
        chk("mem_addr", 64'(mem_addr), 64'({fill_ln, 1'(beat)}));
        wait_c++;
        if (wait_c == lat) begin
          mem_rdy = 1'b1;
          mem_rd_data = mem[{fill_ln, 1'(beat)}];
          wait_c = 0;
          beat++;
        end
      end
      #1;
      if (pc_stall) begin
        stall++;
        chk("stall_instr_nop", 64'(instr), 64'h0);
      end
      if (ic_we) begin
        chk("ic_wr_data", ic_wr_data, line_of(fill_ln));
        fill_ln = cur_pc[15:2];
        beat = 0;
      end
      if (instr_vld) begin
        chk("instr", 64'(instr), 64'(instr_of(fp)));
        done = 1'b1;
      end
    end
    chk("fetch_done", 64'(done), 64'h1);
    chk("stall_cycles", 64'(stall), 64'(exp_stall));
    @(posedge clk); #1;
    chk_cnts("fetch");
  endtask

  // Single-cycle lookup on a line the model knows is cached
  task automatic hit_step(input logic [15:0] a, input bit fl);
    @(negedge clk);
    pc = a; fetch_en = 1'b1; flush = fl; mem_rdy = 1'b0; #1;
    chk("hit_instr",    64'(instr),     fl ? 64'h0 : 64'(instr_of(a)));
    chk("hit_vld",      64'(instr_vld), fl ? 64'h0 : 64'h1);
    chk("hit_pc_stall", 64'(pc_stall),  64'h0);
    chk("hit_ic_re",    64'(ic_re),     64'h1);
    chk("hit_ic_addr",  64'(ic_addr),   64'(a[15:2]));
    m_hit = sat_inc(m_hit);
    @(posedge clk); #1;
    chk_cnts("hit");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_before, n;
    logic [13:0] ln_r;
    logic [15:0] a_r;

    for (int i = 0; i < 32768; i++) mem[i] = $urandom;
    mem[0] = 32'h2222_1111;
    mem[1] = 32'h4444_3333;

    rst_n = 1'b0; pc = 16'h1234; fetch_en = 1'b1; flush = 1'b0;
    mem_rdy = 1'b0; mem_rd_data = '0;
    #12;
    chk("rst_instr",      64'(instr),      64'h0);
    chk("rst_instr_vld",  64'(instr_vld),  64'h0);
    chk("rst_pc_stall",   64'(pc_stall),   64'h0);
    chk("rst_ic_re",      64'(ic_re),      64'h0);
    chk("rst_ic_we",      64'(ic_we),      64'h0);
    chk("rst_mem_re",     64'(mem_re),     64'h0);
    chk("rst_ic_addr",    64'(ic_addr),    64'h0);
    chk("rst_mem_addr",   64'(mem_addr),   64'h0);
    chk("rst_ic_wr_data", ic_wr_data,      64'h0);
    chk_cnts("rst");

    @(negedge clk);
    rst_n = 1'b1; fetch_en = 1'b0;

    // Cold miss on line 0 with 4-cycle beats, then warm sweep
    fetch(16'h0000, 4, 1'b0, 16'h0);
    hit_step(16'h0001, 1'b0);
    hit_step(16'h0002, 1'b0);
    hit_step(16'h0003, 1'b0);
    hit_step(16'h0002, 1'b1);

    // Redirect with flush while the fill of line 2 is in REQ1
    fetch(16'h0008, 2, 1'b1, 16'h0040);
    hit_step(16'h0009, 1'b0);

    // Spurious mem_rdy while idle
    @(negedge clk);
    fetch_en = 1'b0; flush = 1'b0; mem_rdy = 1'b1; mem_rd_data = 32'hDEAD_BEEF; #1;
    chk("spur_instr_vld", 64'(instr_vld), 64'h0);
    chk("spur_pc_stall",  64'(pc_stall),  64'h0);
    chk("spur_instr",     64'(instr),     64'h0);
    @(negedge clk);
    mem_rdy = 1'b0; #1;
    chk("spur_mem_re",    64'(mem_re),    64'h0);
    chk("spur_pc_stall2", 64'(pc_stall),  64'h0);
    chk_cnts("spur");
    hit_step(16'h0000, 1'b0);

    // Reset while the fill of line 0x40 sits in REQ1
    @(negedge clk);
    pc = 16'h0100; fetch_en = 1'b1; flush = 1'b0; mem_rdy = 1'b0;
    @(negedge clk);
    mem_rdy = 1'b1; mem_rd_data = mem[15'h0080];
    @(negedge clk);
    mem_rdy = 1'b0; #1;
    chk("req1_mem_addr", 64'(mem_addr), 64'h81);
    we_before = we_pulses;
    rst_n = 1'b0; #1;
    chk("mid_rst_mem_re",   64'(mem_re),   64'h0);
    chk("mid_rst_ic_we",    64'(ic_we),    64'h0);
    chk("mid_rst_pc_stall", 64'(pc_stall), 64'h0);
    m_hit = 0; m_miss = 0;
    chk_cnts("mid_rst");
    @(negedge clk);
    rst_n = 1'b1; fetch_en = 1'b0; #1;
    chk("mid_rst_no_write", 64'(we_pulses), 64'(we_before));
    chk("mid_rst_line_cold", 64'(cache_vld[14'h40]), 64'h0);
    chk("mid_rst_idle_stall", 64'(pc_stall), 64'h0);
    fetch(16'h0102, 3, 1'b0, 16'h0);

    // Fastest and slow memory
    fetch(16'h0200, 1, 1'b0, 16'h0);
    fetch(16'h0301, 7, 1'b0, 16'h0);

    // Randomized mix of hits, misses, latencies and flushed hits
    for (int i = 0; i < 40; i++) begin
      ln_r = 14'h100 + 14'($urandom_range(0, 15));
      a_r  = {ln_r, 2'($urandom_range(0, 3))};
      if (exp_vld[ln_r] && $urandom_range(0, 3) == 0)
        hit_step(a_r, 1'b1);
      else
        fetch(a_r, int'($urandom_range(1, 6)), 1'b0, 16'h0);
    end

    // Drive hit_cnt past saturation with back-to-back hits
    n = 65536 - m_hit + 3;
    @(negedge clk);
    pc = 16'h0000; fetch_en = 1'b1; flush = 1'b0; mem_rdy = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    m_hit = (m_hit + n > 65535) ? 65535 : m_hit + n;
    chk("sat_hit_cnt", 64'(hit_cnt), 64'(m_hit));
    hit_step(16'h0001, 1'b0);
    chk("sat_hold", 64'(hit_cnt), 64'hFFFF);

    @(negedge clk);
    fetch_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
